// File: rtl/shared_data_ram.sv
// Multi-port word-addressed data RAM with round-robin arbitration.
// Optional SHARED_DATA_RAM_BOUNDS_CHECK_EN flags addresses >= DEPTH.
module shared_data_ram #(
   parameter int N_PORTS = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [N_PORTS-1:0]        mem_read,
   input  logic [N_PORTS-1:0]        mem_write,
   input  logic [N_PORTS*ADDR_W-1:0] mem_addr,
   input  logic [N_PORTS*DATA_W-1:0] mem_data_w,
   output logic [N_PORTS*DATA_W-1:0] mem_data_r,
   output logic [N_PORTS-1:0]        mem_wait,
   output logic [N_PORTS-1:0]        mem_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   grant;
   logic [PTR_W-1:0]   pick;
   logic               op_wr;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [CNT_W-1:0]   cnt;
   logic [N_PORTS-1:0] req;
   logic [IDX_W-1:0]   idx;
   logic               oob;
   logic               fire;

   logic [DATA_W-1:0]  mem [DEPTH];

   assign req  = mem_read | mem_write;
   assign idx  = addr_q[IDX_W-1:0];
   assign fire = en && (state == BUSY) && (cnt == '0);

`ifdef SHARED_DATA_RAM_BOUNDS_CHECK_EN
   assign oob = |(addr_q >> IDX_W);
`else
   logic unused_addr_hi;
   assign unused_addr_hi = |(addr_q >> IDX_W);
   assign oob = 1'b0;
`endif

   // First requesting port at or after rr_ptr, wrapping modulo N_PORTS.
   always_comb begin
      logic found;
      int   j;
      pick  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         j = (int'(rr_ptr) + k) % N_PORTS;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = PTR_W'(j);
         end
      end
   end

   // Access FSM: arbitrate in IDLE, count down in BUSY, hand back in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant   <= '0;
         op_wr   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else if (en) begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  grant   <= pick;
                  op_wr   <= mem_write[pick];
                  addr_q  <= mem_addr[pick*ADDR_W +: ADDR_W];
                  wdata_q <= mem_data_w[pick*DATA_W +: DATA_W];
                  cnt     <= CNT_W'(LATENCY - 1);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  if (!op_wr) rdata_q <= oob ? '0 : mem[idx];
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               rr_ptr <= (grant == PTR_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array write on the final BUSY edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (fire && op_wr && !oob) mem[idx] <= wdata_q;
   end

   // Per-port stall, read data and error, decoded from the held state.
   always_comb begin
      logic done_i;
      for (int i = 0; i < N_PORTS; i++) begin
         done_i = (state == DONE) && (grant == PTR_W'(i));
         mem_wait[i] = req[i] & ~done_i;
         mem_data_r[i*DATA_W +: DATA_W] = (done_i && !op_wr) ? rdata_q : '0;
         mem_err[i] = done_i & oob;
      end
   end

endmodule

// File: doc/shared_data_ram.md
Name: shared_data_ram

Overview:
- Parametrised multi-port data memory for the multicore build; successor to the single-port simulation RAM.
- Serves N_PORTS cores on the existing mem_read/mem_write/mem_wait handshake.
- Round-robin arbitration and a configurable access latency; one access in flight at a time.
- Word-addressed array: the address value is the word index, with no byte shift.

Parameters:
- N_PORTS, 2, number of core ports (1..8).
- DATA_W, 32, data word width.
- ADDR_W, 32, address width per port.
- DEPTH, 1024, words in the array; power of two.
- LATENCY, 2, BUSY cycles per access (1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, FSM, counter and pointer hold.
- mem_read  in  N_PORTS  per-port read request, held until mem_wait low.
- mem_write  in  N_PORTS  per-port write request, held until mem_wait low.
- mem_addr  in  N_PORTS*ADDR_W  per-port address, port i in slice [i*ADDR_W +: ADDR_W].
- mem_data_w  in  N_PORTS*DATA_W  per-port write data.
- mem_data_r  out  N_PORTS*DATA_W  per-port read data.
- mem_wait  out  N_PORTS  per-port stall.
- mem_err  out  N_PORTS  per-port out-of-range flag; tied 0 unless the optional feature is enabled.

Behaviour:
- Port i requests when req[i] = mem_read[i] | mem_write[i]. If both are set, the access is a write.
- Reset values: state IDLE, rr_ptr 0, grant 0, counter 0, rdata_q 0, all outputs 0.
- Reset does not clear the array. Reset mid-access aborts it with no array write.
- FSM states: IDLE, BUSY, DONE.
- IDLE, when any req: select the first requesting port scanning rr_ptr, rr_ptr+1, ... modulo N_PORTS.
  - Latch grant, op, addr and wdata; counter <= LATENCY-1; go to BUSY.
- BUSY: counter decrements each cycle.
  - On the edge where counter==0, perform the array access using the latched values.
  - Write: array[idx] <= wdata. Read: rdata_q <= array[idx].
  - Then go to DONE.
- DONE, one cycle: rr_ptr <= grant+1 modulo N_PORTS; go to IDLE.
- mem_wait[i] = req[i] & !(state==DONE && grant==i), combinational.
  - A port with no request always sees mem_wait 0.
- mem_data_r for port i = rdata_q when state==DONE && grant==i && op==read, else 0.
- Timing: request first seen in IDLE at cycle t, mem_wait low at cycle t+LATENCY+1. Each access therefore costs LATENCY+2 cycles including the return to IDLE.
- The core samples the result and advances on the edge ending DONE. It may keep its request asserted for a new access; that request is re-arbitrated in the following IDLE.
- Request inputs are sampled only in IDLE. Changes to addr or data after grant are ignored.
- Fairness: a continuously requesting port is granted at most once per N_PORTS grants while others request.
- Index idx = addr mod DEPTH (low log2(DEPTH) bits); out-of-range addresses wrap.
- en low: FSM, counter, rr_ptr and rdata_q hold. Outputs keep their combinational values from the held state; no array write occurs.

Optional Feature:
- Macro: SHARED_DATA_RAM_BOUNDS_CHECK_EN.
- Defined: an address >= DEPTH is out of range.
  - Read returns 0 and the write is dropped.
  - mem_err[grant] is high for exactly the DONE cycle; otherwise mem_err is 0.
- Undefined: mem_err is constant 0 and addresses wrap modulo DEPTH.

Test Plan:
- Single read, LATENCY=2, array[200]=4. Port0 mem_read, addr 200 at cycle 0 -> mem_wait[0] high cycles 0-2, low at cycle 3 with mem_data_r[0]=4.
- Write then read. Port0 writes 5 to addr 200, then reads addr 200 -> read returns 5; port1 outputs stay 0 throughout.
- Contention, N_PORTS=2. Both ports read from cycle 0 (array[100]=1, array[300]=0x1ABCDEF0) -> port0 completes cycle 3 with 1, port1 completes cycle 7 with 0x1ABCDEF0. With both requesting continuously, grants alternate 0,1,0,1.
- Read and write together on port0 (wdata 0xAA, addr 50) -> treated as write; a later read of 50 returns 0xAA.
- Reset mid-write. rst_n low during BUSY of a write of 7 to addr 10 (previously 3) -> outputs 0 immediately; array[10] stays 3; rr_ptr 0.
- Bounds, DEPTH=1024. Read addr 1024 -> without the macro returns array[0]; with the macro returns 0 and mem_err[0]=1 for one cycle.
